spi_reg_slave: RTL and testbench

- SPI responder that models a DSD1792-style control port, for loopback tests against the SPI master.
- Oversamples sck, ss and mosi in the system clock domain.
- Decodes frames of one address byte (bit 7 = R/W, bits 6:0 = register index) followed by one data byte.
- Writes an internal register file, or shifts register contents back on miso; also exposes write strobes and a parallel read port to the rest of the design.

---
 rtl/spi_reg_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 28 ++
 rtl/spi_reg_slave.sv | 209 ++++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared encodings and field positions for the SPI register responder.
// The address byte carries the R/W flag in its MSB and a 7-bit register index.
package spi_reg_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int RW_BIT = 7;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      WR   = 3'd2,
      RD   = 3'd3,
      HOLD = 3'd4
   } state_e;

   function automatic logic idx_valid(input logic [ADDR_W-1:0] idx, input int num_regs);
      return ({25'd0, idx} < num_regs);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third flop for rise/fall detection.
// The reset value lets active-low inputs such as ss start deasserted.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [2:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {3{RST_VAL}};
      end else begin
         sync_q <= {sync_q[1:0], d_i};
      end
   end

   assign q_o    = sync_q[1];
   assign rise_o = sync_q[1] & ~sync_q[2];
   assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI register responder: one address byte (R/W + index) then one data byte,
// backed by a register file with a write strobe and a registered host read port.
//
//   state | meaning
//   IDLE  | waiting for ss to fall
//   ADDR  | shifting in the address byte
//   WR    | shifting in the write data byte
//   RD    | shifting register contents out on miso
//   HOLD  | frame complete, ignore sck until ss rises
module spi_reg_slave
   import spi_reg_pkg::*;
#(
   parameter int                NUM_REGS  = 32,
   parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sck,
   input  logic              ss,
   input  logic              mosi,
   output logic              miso,
   output logic              reg_wr_valid,
   output logic [ADDR_W-1:0] reg_wr_addr,
   output logic [DATA_W-1:0] reg_wr_data,
   input  logic [ADDR_W-1:0] host_rd_addr,
   output logic [DATA_W-1:0] host_rd_data
);

   logic sck_rise, ss_rise, ss_fall, mosi_s;
   logic sck_level_unused, sck_fall_unused, ss_level_unused;
   logic mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
      .clk    (clk),
      .reset  (reset),
      .d_i    (sck),
      .q_o    (sck_level_unused),
      .rise_o (sck_rise),
      .fall_o (sck_fall_unused)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
      .clk    (clk),
      .reset  (reset),
      .d_i    (ss),
      .q_o    (ss_level_unused),
      .rise_o (ss_rise),
      .fall_o (ss_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk    (clk),
      .reset  (reset),
      .d_i    (mosi),
      .q_o    (mosi_s),
      .rise_o (mosi_rise_unused),
      .fall_o (mosi_fall_unused)
   );

   state_e              state_q, state_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [DATA_W-1:0]   rd_shift_q, rd_shift_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                miso_q, miso_d;
   logic                wr_valid_q, wr_valid_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                wr_en;
   logic [DATA_W-1:0]   byte_in;
   logic [DATA_W-1:0]   host_rd_data_q;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];

   // Out-of-range indices read as zero without indexing past the array.
   function automatic logic [DATA_W-1:0] reg_at(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (a == ADDR_W'(i)) r = regs_q[i];
      end
      return r;
   endfunction

   assign byte_in = {shift_q[DATA_W-2:0], mosi_s};

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rd_shift_d = rd_shift_q;
      idx_d      = idx_q;
      miso_d     = miso_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_en      = 1'b0;

      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               bit_cnt_d = '0;
               shift_d   = '0;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            if (sck_rise) begin
               shift_d   = byte_in;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  idx_d = byte_in[ADDR_W-1:0];
                  if (byte_in[RW_BIT]) begin
                     state_d    = RD;
                     rd_shift_d = reg_at(byte_in[ADDR_W-1:0]);
                     miso_d     = rd_shift_d[DATA_W-1];
                  end else begin
                     state_d = WR;
                  end
               end
            end
         end
         WR: begin
            if (sck_rise) begin
               shift_d   = byte_in;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (idx_valid(idx_q, NUM_REGS)) begin
                     wr_en      = 1'b1;
                     wr_valid_d = 1'b1;
                     wr_addr_d  = idx_q;
                     wr_data_d  = byte_in;
                  end
                  state_d = HOLD;
               end
            end
         end
         RD: begin
            if (sck_rise) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  miso_d  = 1'b0;
                  state_d = HOLD;
               end else begin
                  rd_shift_d = {rd_shift_q[DATA_W-2:0], 1'b0};
                  miso_d     = rd_shift_q[DATA_W-2];
               end
            end
         end
         HOLD: ;
         default: state_d = IDLE;
      endcase

      // Deselect wins over the FSM but not over a write committed in the same cycle.
      if (ss_rise && (state_q != IDLE)) begin
         state_d = IDLE;
         miso_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rd_shift_q <= '0;
         idx_q      <= '0;
         miso_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rd_shift_q <= rd_shift_d;
         idx_q      <= idx_d;
         miso_q     <= miso_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr_d == ADDR_W'(i)) regs_q[i] <= wr_data_d;
         end
      end
   end

   // Samples regs_q before this cycle's write lands, so a colliding read sees the old value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         host_rd_data_q <= '0;
      end else begin
         host_rd_data_q <= reg_at(host_rd_addr);
      end
   end

   assign miso         = miso_q;
   assign reg_wr_valid = wr_valid_q;
   assign reg_wr_addr  = wr_addr_q;
   assign reg_wr_data  = wr_data_q;
   assign host_rd_data = host_rd_data_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: SPI master at sck = clk/8 plus host read port checks.
module tb_spi_reg_slave;

   logic       clk = 1'b0;
   logic       reset;
   logic       sck;
   logic       ss;
   logic       mosi;
   logic       miso;
   logic       reg_wr_valid;
   logic [6:0] reg_wr_addr;
   logic [7:0] reg_wr_data;
   logic [6:0] host_rd_addr;
   logic [7:0] host_rd_data;

   int         checks = 0;
   int         passes = 0;
   int         pulse_cnt = 0;
   logic [6:0] last_addr = '0;
   logic [7:0] last_data = '0;
   logic       miso_hi = 1'b0;

   always #5 clk = ~clk;

   spi_reg_slave #(.NUM_REGS(32), .RESET_VAL(8'h00)) dut (
      .clk          (clk),
      .reset        (reset),
      .sck          (sck),
      .ss           (ss),
      .mosi         (mosi),
      .miso         (miso),
      .reg_wr_valid (reg_wr_valid),
      .reg_wr_addr  (reg_wr_addr),
      .reg_wr_data  (reg_wr_data),
      .host_rd_addr (host_rd_addr),
      .host_rd_data (host_rd_data)
   );

   always @(negedge clk) begin
      if (reg_wr_valid === 1'b1) begin
         pulse_cnt = pulse_cnt + 1;
         last_addr = reg_wr_addr;
         last_data = reg_wr_data;
      end
      if (miso === 1'b1) miso_hi = 1'b1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   // miso is captured at the end of each low phase, i.e. the bit held for that data slot.
   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < n; i++) begin
         mosi = tx[3'(7 - i)];
         clk_wait(4);
         rx = {rx[6:0], miso};
         sck = 1'b1;
         clk_wait(4);
         sck = 1'b0;
      end
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] d, output logic [7:0] rx);
      logic [7:0] dummy;
      ss = 1'b0;
      clk_wait(4);
      spi_bits(a, 8, dummy);
      spi_bits(d, 8, rx);
      clk_wait(4);
      ss = 1'b1;
      clk_wait(8);
   endtask

   task automatic host_read(input logic [6:0] a, output logic [7:0] d);
      host_rd_addr = a;
      clk_wait(1);
      d = host_rd_data;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      sck = 1'b0;
      ss = 1'b1;
      mosi = 1'b0;
      host_rd_addr = '0;
      clk_wait(3);
      reset = 1'b0;
      clk_wait(3);
      checks++; if (miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", miso); else passes++;
      checks++; if (reg_wr_valid !== 1'b0) $display("FAIL reset_wr_valid: got %b want 0", reg_wr_valid); else passes++;
      checks++; if (reg_wr_addr !== 7'h00) $display("FAIL reset_wr_addr: got %h want 00", reg_wr_addr); else passes++;
      checks++; if (reg_wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", reg_wr_data); else passes++;
      checks++; if (host_rd_data !== 8'h00) $display("FAIL reset_host_rd: got %h want 00", host_rd_data); else passes++;
   endtask

   task automatic test_single_write;
      logic [7:0] rx;
      pulse_cnt = 0;
      frame(8'h05, 8'hA5, rx);
      checks++; if (pulse_cnt !== 1) $display("FAIL wr_pulse_count: got %0d want 1", pulse_cnt); else passes++;
      checks++; if (last_addr !== 7'h05) $display("FAIL wr_addr: got %h want 05", last_addr); else passes++;
      checks++; if (last_data !== 8'hA5) $display("FAIL wr_data: got %h want a5", last_data); else passes++;
      host_rd_addr = 7'h00;
      clk_wait(2);
      host_rd_addr = 7'h05;
      #1;
      checks++; if (host_rd_data !== 8'h00) $display("FAIL host_rd_latency: got %h want 00", host_rd_data); else passes++;
      clk_wait(1);
      checks++; if (host_rd_data !== 8'hA5) $display("FAIL host_rd_reg5: got %h want a5", host_rd_data); else passes++;
   endtask

   task automatic test_read_back;
      logic [7:0] rx;
      logic [7:0] hd;
      frame(8'h03, 8'h3C, rx);
      pulse_cnt = 0;
      frame(8'h83, 8'h00, rx);
      checks++; if (rx !== 8'h3C) $display("FAIL rd_miso_reg3: got %h want 3c", rx); else passes++;
      checks++; if (pulse_cnt !== 0) $display("FAIL rd_no_pulse: got %0d want 0", pulse_cnt); else passes++;
      host_read(7'h03, hd);
      checks++; if (hd !== 8'h3C) $display("FAIL rd_host_reg3: got %h want 3c", hd); else passes++;
   endtask

   task automatic test_out_of_range;
      logic [7:0] rx;
      logic [7:0] hd;
      pulse_cnt = 0;
      frame(8'h40, 8'hFF, rx);
      checks++; if (pulse_cnt !== 0) $display("FAIL oor_no_pulse: got %0d want 0", pulse_cnt); else passes++;
      host_read(7'h00, hd);
      checks++; if (hd !== 8'h00) $display("FAIL oor_no_alias_reg0: got %h want 00", hd); else passes++;
      host_read(7'h40, hd);
      checks++; if (hd !== 8'h00) $display("FAIL oor_host_rd: got %h want 00", hd); else passes++;
      frame(8'hC0, 8'h00, rx);
      checks++; if (rx !== 8'h00) $display("FAIL oor_spi_rd: got %h want 00", rx); else passes++;
   endtask

   task automatic test_abort;
      logic [7:0] rx;
      logic [7:0] hd;
      pulse_cnt = 0;
      ss = 1'b0;
      clk_wait(4);
      spi_bits(8'h02, 8, rx);
      spi_bits(8'hF0, 4, rx);
      clk_wait(2);
      ss = 1'b1;
      clk_wait(8);
      checks++; if (pulse_cnt !== 0) $display("FAIL abort_no_pulse: got %0d want 0", pulse_cnt); else passes++;
      host_read(7'h02, hd);
      checks++; if (hd !== 8'h00) $display("FAIL abort_reg2_kept: got %h want 00", hd); else passes++;
      frame(8'h02, 8'h11, rx);
      checks++; if (pulse_cnt !== 1) $display("FAIL abort_next_pulse: got %0d want 1", pulse_cnt); else passes++;
      checks++; if (last_data !== 8'h11) $display("FAIL abort_next_data: got %h want 11", last_data); else passes++;
      host_read(7'h02, hd);
      checks++; if (hd !== 8'h11) $display("FAIL abort_next_reg2: got %h want 11", hd); else passes++;
   endtask

   task automatic test_overclock;
      logic [7:0] rx;
      logic [7:0] hd;
      pulse_cnt = 0;
      miso_hi = 1'b0;
      ss = 1'b0;
      clk_wait(4);
      spi_bits(8'h01, 8, rx);
      spi_bits(8'h7E, 8, rx);
      spi_bits(8'hFF, 8, rx);
      clk_wait(4);
      ss = 1'b1;
      clk_wait(8);
      checks++; if (pulse_cnt !== 1) $display("FAIL ovr_pulse_count: got %0d want 1", pulse_cnt); else passes++;
      checks++; if (last_addr !== 7'h01) $display("FAIL ovr_addr: got %h want 01", last_addr); else passes++;
      checks++; if (last_data !== 8'h7E) $display("FAIL ovr_data: got %h want 7e", last_data); else passes++;
      checks++; if (miso_hi !== 1'b0) $display("FAIL ovr_miso_quiet: got %b want 0", miso_hi); else passes++;
      host_read(7'h01, hd);
      checks++; if (hd !== 8'h7E) $display("FAIL ovr_host_reg1: got %h want 7e", hd); else passes++;
   endtask

   task automatic test_async_reset;
      logic [7:0] rx;
      logic [7:0] hd;
      ss = 1'b0;
      clk_wait(4);
      spi_bits(8'h83, 8, rx);
      spi_bits(8'h00, 3, rx);
      checks++; if (miso !== 1'b1) $display("FAIL arst_miso_before: got %b want 1", miso); else passes++;
      #2 reset = 1'b1;
      #1;
      checks++; if (miso !== 1'b0) $display("FAIL arst_miso_now: got %b want 0", miso); else passes++;
      ss = 1'b1;
      clk_wait(3);
      reset = 1'b0;
      clk_wait(8);
      host_read(7'h03, hd);
      checks++; if (hd !== 8'h00) $display("FAIL arst_reg3: got %h want 00", hd); else passes++;
      host_read(7'h05, hd);
      checks++; if (hd !== 8'h00) $display("FAIL arst_reg5: got %h want 00", hd); else passes++;
      host_read(7'h02, hd);
      checks++; if (hd !== 8'h00) $display("FAIL arst_reg2: got %h want 00", hd); else passes++;
      pulse_cnt = 0;
      frame(8'h06, 8'h5A, rx);
      checks++; if (pulse_cnt !== 1) $display("FAIL arst_next_pulse: got %0d want 1", pulse_cnt); else passes++;
      checks++; if (last_addr !== 7'h06) $display("FAIL arst_next_addr: got %h want 06", last_addr); else passes++;
      frame(8'h86, 8'h00, rx);
      checks++; if (rx !== 8'h5A) $display("FAIL arst_next_read: got %h want 5a", rx); else passes++;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_back();
      test_out_of_range();
      test_abort();
      test_overclock();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
